// File: rtl/uop_cache_pkg.sv
// Shared types for the tagged micro-op cache: flush FSM states and entry-word layout.
// Entry word is {valid, tag, data}; data sits at bit 0, tag above it, valid on top.
// Helper functions give the field offsets for any TAG_W/DATA_W parameterisation.
package uop_cache_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   // Default geometry and the field offsets derived from it.
   localparam int TAG_W      = 8;
   localparam int DATA_W     = 32;
   localparam int DATA_LSB   = 0;
   localparam int TAG_LSB    = DATA_W;
   localparam int VALID_BIT  = TAG_W + DATA_W;
   localparam int ENTRY_W    = 1 + TAG_W + DATA_W;

   function automatic int ent_tag_lsb(input int data_w);
      return data_w;
   endfunction

   function automatic int ent_valid_bit(input int tag_w, input int data_w);
      return tag_w + data_w;
   endfunction

   function automatic int ent_width(input int tag_w, input int data_w);
      return 1 + tag_w + data_w;
   endfunction

endpackage

// File: rtl/uop_cache_tagged_sdp_ram.sv
// Inferred simple dual-port RAM: one write port, one registered read port.
// Ports: clk; we_i/waddr_i/wdata_i write; raddr_i in, rdata_o out one cycle later.
// A same-address read and write returns the old contents (no internal forwarding).
module sdp_ram #(
   parameter int WIDTH  = 41,
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WIDTH-1:0]  wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WIDTH-1:0]  rdata_o
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   // Read and write in the same process with non-blocking updates: the read
   // samples the array before this edge's write lands, giving old data.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[waddr_i] <= wdata_i;
      end
      rdata_q <= mem[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/uop_cache_tagged.sv
// Direct-mapped micro-op cache with per-entry tag/valid, flush sweep FSM and profiling counters.
// Ports: clk/reset; rd_en/rd_addr -> rd_valid/rd_hit/rd_data (1 cycle); wr_en/wr_addr/wr_data fill;
//        flush pulse, busy during sweep; hit_cnt/miss_cnt saturating counters.
module uop_cache_tagged
   import uop_cache_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int INDEX_W = 9,
   parameter int TAG_W   = 8,
   parameter int BYPASS  = 1,
   parameter int CNT_W   = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     rd_en,
   input  logic [TAG_W+INDEX_W-1:0] rd_addr,
   output logic                     rd_valid,
   output logic                     rd_hit,
   output logic [DATA_W-1:0]        rd_data,
   input  logic                     wr_en,
   input  logic [TAG_W+INDEX_W-1:0] wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     flush,
   output logic                     busy,
   output logic [CNT_W-1:0]         hit_cnt,
   output logic [CNT_W-1:0]         miss_cnt
);

   localparam int ENT_W = ent_width(TAG_W, DATA_W);
   localparam int VBIT  = ent_valid_bit(TAG_W, DATA_W);
   localparam int TLSB  = ent_tag_lsb(DATA_W);

   state_t               state_q, state_d;
   logic [INDEX_W-1:0]   sweep_idx_q, sweep_idx_d;
   logic                 busy_q;
   logic                 rd_vld_q;
   logic                 byp_q;
   logic [TAG_W-1:0]     rd_tag_q;
   logic [ENT_W-1:0]     byp_word_q;
   logic [CNT_W-1:0]     hit_cnt_q, miss_cnt_q;

   logic                 rd_acc, wr_acc;
   logic                 ram_we;
   logic [INDEX_W-1:0]   ram_waddr;
   logic [ENT_W-1:0]     ram_wdata, ram_rdata, fill_word, entry;
   logic                 hit;

   assign fill_word = {1'b1, wr_addr[TAG_W+INDEX_W-1:INDEX_W], wr_data};

   // A read issued in the flush cycle still completes; the write does not.
   assign rd_acc = rd_en & ~busy_q;
   assign wr_acc = wr_en & ~busy_q & ~flush;

   always_comb begin
      state_d     = state_q;
      sweep_idx_d = sweep_idx_q;
      ram_we      = 1'b0;
      ram_waddr   = wr_addr[INDEX_W-1:0];
      ram_wdata   = fill_word;
      case (state_q)
         IDLE: begin
            if (flush) begin
               state_d     = SWEEP;
               sweep_idx_d = '0;
            end else begin
               ram_we = wr_acc;
            end
         end
         SWEEP: begin
            ram_we    = 1'b1;
            ram_waddr = sweep_idx_q;
            ram_wdata = '0;
            if (&sweep_idx_q) begin
               state_d = IDLE;
            end else begin
               sweep_idx_d = sweep_idx_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   sdp_ram #(
      .WIDTH  (ENT_W),
      .ADDR_W (INDEX_W)
   ) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .raddr_i (rd_addr[INDEX_W-1:0]),
      .rdata_o (ram_rdata)
   );

   // The RAM returns old data on collision; the forwarding register supplies the
   // freshly written word instead when BYPASS is enabled.
   assign entry   = byp_q ? byp_word_q : ram_rdata;
   assign hit     = rd_vld_q & entry[VBIT] & (entry[VBIT-1:TLSB] == rd_tag_q);
   assign rd_valid = rd_vld_q;
   assign rd_hit   = hit;
   assign rd_data  = hit ? entry[DATA_W-1:0] : '0;
   assign busy     = busy_q;
   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= SWEEP;
         sweep_idx_q <= '0;
         busy_q      <= 1'b1;
         rd_vld_q    <= 1'b0;
         byp_q       <= 1'b0;
         hit_cnt_q   <= '0;
         miss_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         sweep_idx_q <= sweep_idx_d;
         busy_q      <= (state_d == SWEEP);
         rd_vld_q    <= rd_acc;
         byp_q       <= (BYPASS != 0) && rd_acc && wr_acc &&
                        (rd_addr[INDEX_W-1:0] == wr_addr[INDEX_W-1:0]);
         // Counters advance in the cycle the result is presented, holding at all-ones.
         if (rd_vld_q) begin
            if (hit) begin
               if (!(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 1'b1;
            end else begin
               if (!(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
            end
         end
      end
   end

   // Pure datapath capture; only consulted while rd_vld_q is set.
   always_ff @(posedge clk) begin
      rd_tag_q   <= rd_addr[TAG_W+INDEX_W-1:INDEX_W];
      byp_word_q <= fill_word;
   end

endmodule

// File: tb/tb_uop_cache_tagged.sv
// Self-checking bench for uop_cache_tagged: table of lookup/fill vectors plus flush and reset sequences.
// Two instances share stimulus: the main one with forwarding, a second one without.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_uop_cache_tagged;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_en, wr_en, flush;
   logic [16:0] rd_addr, wr_addr;
   logic [31:0] wr_data;

   logic        rd_valid, rd_hit, busy;
   logic [31:0] rd_data;
   logic [15:0] hit_cnt, miss_cnt;

   logic        nb_rd_valid, nb_rd_hit, nb_busy;
   logic [31:0] nb_rd_data;
   logic [15:0] nb_hit_cnt, nb_miss_cnt;

   int n_vec = 0;
   int n_bad = 0;
   int exp_hit = 0, exp_miss = 0, nb_exp_hit = 0, nb_exp_miss = 0;

   always #5 clk = ~clk;

   uop_cache_tagged #(.DATA_W(32), .INDEX_W(9), .TAG_W(8), .BYPASS(1), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid),
      .rd_hit(rd_hit), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .flush(flush), .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

   uop_cache_tagged #(.DATA_W(32), .INDEX_W(9), .TAG_W(8), .BYPASS(0), .CNT_W(16)) dut_nb (
      .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(nb_rd_valid),
      .rd_hit(nb_rd_hit), .rd_data(nb_rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .flush(flush), .busy(nb_busy), .hit_cnt(nb_hit_cnt), .miss_cnt(nb_miss_cnt));

   typedef struct {
      logic        rd_en;
      logic [16:0] rd_addr;
      logic        wr_en;
      logic [16:0] wr_addr;
      logic [31:0] wr_data;
      logic        exp_vld;
      logic        exp_hit;
      logic [31:0] exp_data;
      logic        exp_hit_nb;
      logic [31:0] exp_data_nb;
   } vec_t;

   vec_t tv [11];

   function automatic logic [16:0] mk(input logic [7:0] t, input logic [8:0] i);
      return {t, i};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Starting on a sample where busy is already high, count busy samples until it drops.
   task automatic count_busy(output int n);
      n = 0;
      while (busy && n < 2000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic idle_inputs();
      rd_en = 1'b0; wr_en = 1'b0; flush = 1'b0;
      rd_addr = '0; wr_addr = '0; wr_data = '0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      int n;
      logic [15:0] k;

      //                rd    rd_addr          wr    wr_addr          wr_data       vld   hit   data          hit_nb data_nb
      tv[0]  = '{1'b1, mk(8'h00,9'h005), 1'b0, 17'h0,            32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      tv[1]  = '{1'b0, 17'h0,            1'b1, mk(8'h12,9'h034), 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
      tv[2]  = '{1'b1, mk(8'h12,9'h034), 1'b0, 17'h0,            32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
      tv[3]  = '{1'b1, mk(8'h13,9'h034), 1'b0, 17'h0,            32'h0,        1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      tv[4]  = '{1'b1, mk(8'h01,9'h010), 1'b1, mk(8'h01,9'h010), 32'hA5A5A5A5, 1'b1, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0};
      tv[5]  = '{1'b1, mk(8'h01,9'h010), 1'b0, 17'h0,            32'h0,        1'b1, 1'b1, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5};
      tv[6]  = '{1'b1, mk(8'h01,9'h010), 1'b1, mk(8'h02,9'h010), 32'h11112222, 1'b1, 1'b0, 32'h0,        1'b1, 32'hA5A5A5A5};
      tv[7]  = '{1'b1, mk(8'h02,9'h010), 1'b0, 17'h0,            32'h0,        1'b1, 1'b1, 32'h11112222, 1'b1, 32'h11112222};
      tv[8]  = '{1'b1, mk(8'h00,9'h005), 1'b1, mk(8'h03,9'h1FF), 32'hCAFEF00D, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0};
      tv[9]  = '{1'b1, mk(8'h03,9'h1FF), 1'b0, 17'h0,            32'h0,        1'b1, 1'b1, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
      tv[10] = '{1'b0, 17'h0,            1'b0, 17'h0,            32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0};

      // ---- Reset state and initial sweep length ----
      idle_inputs();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_rd_hit", {31'd0, rd_hit}, 32'd0);
      chk("rst_rd_data", rd_data, 32'd0);
      chk("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
      chk("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
      reset = 1'b0;
      count_busy(n);
      chk("init_sweep_len", n, 32'd512);

      // ---- Table of lookups and fills ----
      for (int i = 0; i < 11; i++) begin
         rd_en = tv[i].rd_en; rd_addr = tv[i].rd_addr;
         wr_en = tv[i].wr_en; wr_addr = tv[i].wr_addr; wr_data = tv[i].wr_data;
         @(negedge clk);
         chk($sformatf("v%0d_valid", i), {31'd0, rd_valid}, {31'd0, tv[i].exp_vld});
         chk($sformatf("v%0d_hit", i), {31'd0, rd_hit}, {31'd0, tv[i].exp_hit});
         chk($sformatf("v%0d_data", i), rd_data, tv[i].exp_data);
         chk($sformatf("v%0d_nb_hit", i), {31'd0, nb_rd_hit}, {31'd0, tv[i].exp_hit_nb});
         chk($sformatf("v%0d_nb_data", i), nb_rd_data, tv[i].exp_data_nb);
         if (tv[i].exp_vld) begin
            if (tv[i].exp_hit) exp_hit++; else exp_miss++;
            if (tv[i].exp_hit_nb) nb_exp_hit++; else nb_exp_miss++;
         end
      end
      idle_inputs();
      chk("tbl_hit_cnt", {16'd0, hit_cnt}, exp_hit);
      chk("tbl_miss_cnt", {16'd0, miss_cnt}, exp_miss);
      chk("tbl_nb_hit_cnt", {16'd0, nb_hit_cnt}, nb_exp_hit);
      chk("tbl_nb_miss_cnt", {16'd0, nb_miss_cnt}, nb_exp_miss);

      // ---- Flush: fill, flush with concurrent read+write, reads during busy ----
      for (int i = 0; i < 4; i++) begin
         wr_en = 1'b1; wr_addr = mk(8'h20, 9'h040 + 9'(i)); wr_data = 32'h100 + i;
         @(negedge clk);
      end
      wr_en = 1'b1; wr_addr = mk(8'h20, 9'h044); wr_data = 32'h999;
      rd_en = 1'b1; rd_addr = mk(8'h20, 9'h041);
      flush = 1'b1;
      @(negedge clk);
      chk("flush_rd_valid", {31'd0, rd_valid}, 32'd1);
      chk("flush_rd_hit", {31'd0, rd_hit}, 32'd1);
      chk("flush_rd_data", rd_data, 32'h101);
      chk("flush_busy", {31'd0, busy}, 32'd1);
      exp_hit++;
      n = 0;
      while (busy && n < 2000) begin
         rd_en   = (n < 8);
         rd_addr = mk(8'h20, 9'h040);
         flush   = (n == 200);
         wr_en   = (n == 510);
         wr_addr = mk(8'h20, 9'h000);
         wr_data = 32'h5555;
         @(negedge clk);
         n++;
         if (n <= 9) chk($sformatf("busy_rd_valid_%0d", n), {31'd0, rd_valid}, 32'd0);
      end
      idle_inputs();
      chk("flush_sweep_len", n, 32'd512);
      for (int i = 0; i < 6; i++) begin
         rd_en = 1'b1;
         rd_addr = (i < 5) ? mk(8'h20, 9'h040 + 9'(i)) : mk(8'h20, 9'h000);
         @(negedge clk);
         chk($sformatf("post_flush_vld_%0d", i), {31'd0, rd_valid}, 32'd1);
         chk($sformatf("post_flush_hit_%0d", i), {31'd0, rd_hit}, 32'd0);
         chk($sformatf("post_flush_data_%0d", i), rd_data, 32'd0);
         exp_miss++;
      end
      idle_inputs();
      @(negedge clk);
      chk("flush_hit_cnt", {16'd0, hit_cnt}, exp_hit);
      chk("flush_miss_cnt", {16'd0, miss_cnt}, exp_miss);

      // ---- Miss counter saturation ----
      k = 16'hFFFE - 16'(exp_miss);
      rd_en = 1'b1; rd_addr = mk(8'h77, 9'h005);
      repeat (k) @(negedge clk);
      rd_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("miss_cnt_fffe", {16'd0, miss_cnt}, 32'hFFFE);
      rd_en = 1'b1;
      repeat (3) @(negedge clk);
      rd_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("miss_cnt_sat", {16'd0, miss_cnt}, 32'hFFFF);
      chk("hit_cnt_steady", {16'd0, hit_cnt}, exp_hit);

      // ---- Reset with a read in flight, then reset mid-sweep ----
      rd_en = 1'b1; rd_addr = mk(8'h20, 9'h040);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_drop_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_clr_hit_cnt", {16'd0, hit_cnt}, 32'd0);
      chk("rst_clr_miss_cnt", {16'd0, miss_cnt}, 32'd0);
      rd_en = 1'b0;
      reset = 1'b0;
      repeat (100) @(negedge clk);
      chk("midsweep_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      count_busy(n);
      chk("restart_sweep_len", n, 32'd512);
      chk("restart_hit_cnt", {16'd0, hit_cnt}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
